mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath, sitting beside the combinational ALU. It runs signed/unsigned multiply and divide over WIDTH iterations with a start/busy/done handshake. It also supports direct HI/LO writes (MTHI/MTLO) and continuously presents HI/LO for MFHI/MFLO.

## Interface

- WIDTH, 32, operand and HI/LO width; must be ≥ 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request to begin an operation; sampled only in IDLE
- opsel  in  5  operation select: C_MULT_S, C_MULT_U, C_DIV_S, C_DIV_U
- reg_a  in  WIDTH  multiplicand / dividend, captured when start is accepted
- reg_b  in  WIDTH  multiplier / divisor, captured when start is accepted
- wr_hi  in  1  write wr_data into HI; honoured only in IDLE
- wr_lo  in  1  write wr_data into LO; honoured only in IDLE
- wr_data  in  WIDTH  data for HI/LO direct writes
- busy  out  1  high in RUN and FIN
- done  out  1  one-cycle pulse: HI/LO hold a new operation result
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

## Operation

- States: IDLE, RUN, FIN.
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, count=0. Reset during RUN/FIN abandons the operation; no partial result is written.
- Start acceptance in IDLE with start=1 and a valid opsel:
  - Latch the operand magnitudes: abs() for the _S ops, raw values for the _U ops.
  - Latch the result signs: quotient/product sign = sign_a XOR sign_b; remainder sign = sign_a.
  - Clear the 2·WIDTH accumulator. Set count=0. Go to RUN.
- An unrecognised opsel with start=1 is ignored; the unit stays in IDLE.
- start while busy is ignored. wr_hi/wr_lo while busy are ignored.
- start and wr_* in the same IDLE cycle: start wins and the writes are dropped.
- wr_hi and wr_lo together: both registers are written.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring, one quotient bit per cycle, MSB first.
- RUN lasts exactly WIDTH cycles. count increments each cycle; at count=WIDTH-1, go to FIN.
- FIN, one cycle:
  - Apply the sign correction.
  - Multiply: {hi,lo} = 2·WIDTH-bit product, which is exact and never overflows.
  - Divide: lo = quotient, hi = remainder.
  - Go to IDLE.
- Divide by zero, both signednesses: lo = all ones, hi = reg_a as captured.
- Signed overflow, most-negative / -1: lo = most-negative, hi = 0. This is the natural magnitude result and is not trapped.

## Timing

- Let start be accepted on edge k.
- busy=1 from edge k+1 through edge k+WIDTH+1, i.e. WIDTH+1 cycles.
- hi/lo update on edge k+WIDTH+1, when FIN exits.
- done=1 for the single cycle following edge k+WIDTH+1, with the new hi/lo visible.
- Latency is WIDTH+1 edges; 33 for WIDTH=32.
- The cycle in which done=1 is IDLE, so a back-to-back start is accepted in that same cycle.
- Direct writes take effect on the next edge; done stays 0 for direct writes.
- hi/lo are held unchanged during RUN and FIN, so MFHI/MFLO read the old values until done.

## Structure

- Add C_MULT_S, C_MULT_U, C_DIV_S, C_DIV_U to the shared ALU opsel constant package alongside the existing C_* codes, 5 bits wide.
- Define the state enum there as mdu_state_t.
- Counter width is $clog2(WIDTH).
- Single module; no sub-module is needed.
- Optionally factor the FIN negation into mdu_sign_fix (combinational, 2·WIDTH).

## Test plan

- C_MULT_U, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 edges, hi=0xFFFFFFFE, lo=0x00000001, done for 1 cycle.
- C_MULT_S, a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- C_DIV_S, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- C_DIV_U, a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
- C_DIV_S, a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- Mid-operation behaviour, in one sequence:
  - During RUN, assert start, wr_hi and wr_lo: all ignored, hi/lo unchanged.
  - Assert rst at cycle 10 of RUN: state=IDLE, hi=lo=0, done never pulses.
  - Then wr_lo with 0x1234 -> lo=0x1234 next cycle, done=0.
  - Then a back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// +------------------------------------------------------------------+
// | mult_div_unit_pkg : shared ALU opsel codes and MDU state type     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package mult_div_unit_pkg;

  localparam int OPSEL_W = 5;

  localparam logic [OPSEL_W-1:0] C_ADD    = 5'h00;
  localparam logic [OPSEL_W-1:0] C_SUB    = 5'h01;
  localparam logic [OPSEL_W-1:0] C_AND    = 5'h02;
  localparam logic [OPSEL_W-1:0] C_OR     = 5'h03;
  localparam logic [OPSEL_W-1:0] C_XOR    = 5'h04;
  localparam logic [OPSEL_W-1:0] C_NOR    = 5'h05;
  localparam logic [OPSEL_W-1:0] C_SLT    = 5'h06;
  localparam logic [OPSEL_W-1:0] C_SLTU   = 5'h07;
  localparam logic [OPSEL_W-1:0] C_MULT_S = 5'h10;
  localparam logic [OPSEL_W-1:0] C_MULT_U = 5'h11;
  localparam logic [OPSEL_W-1:0] C_DIV_S  = 5'h12;
  localparam logic [OPSEL_W-1:0] C_DIV_U  = 5'h13;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_t;

  function automatic logic is_mdu_op(input logic [OPSEL_W-1:0] op);
    return (op == C_MULT_S) || (op == C_MULT_U) || (op == C_DIV_S) || (op == C_DIV_U);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_if.sv
// +------------------------------------------------------------------+
// | mult_div_unit_if : start/busy/done handshake and HI/LO access     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic               start;
  logic [OPSEL_W-1:0] opsel;
  logic [WIDTH-1:0]   reg_a;
  logic [WIDTH-1:0]   reg_b;
  logic               wr_hi;
  logic               wr_lo;
  logic [WIDTH-1:0]   wr_data;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output start, opsel, reg_a, reg_b, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, opsel, reg_a, reg_b, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// +------------------------------------------------------------------+
// | mult_div_unit : iterative signed/unsigned MULT/DIV with HI/LO     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  mult_div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state;
  mdu_state_t         state_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               op_signed;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] acc_mul;
  logic [2*WIDTH-1:0] acc_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept    = (state == MDU_IDLE) && bus.start && is_mdu_op(bus.opsel);
  assign op_signed = (bus.opsel == C_MULT_S) || (bus.opsel == C_DIV_S);
  assign op_div    = (bus.opsel == C_DIV_S) || (bus.opsel == C_DIV_U);
  assign sign_a    = op_signed & bus.reg_a[WIDTH-1];
  assign sign_b    = op_signed & bus.reg_b[WIDTH-1];
  assign mag_a     = sign_a ? (~bus.reg_a + 1'b1) : bus.reg_a;
  assign mag_b     = sign_b ? (~bus.reg_b + 1'b1) : bus.reg_b;

  // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (op_b[0] ? op_a : '0)};
  assign acc_mul = {mul_sum, acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half collects quotient bits.
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], op_a[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, op_b});
  assign rem_diff = rem_sh[WIDTH-1:0] - op_b;
  assign acc_div  = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};

  assign prod_fix = neg_q ? (~acc + 1'b1) : acc;
  assign quo_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE: if (accept) state_next = MDU_RUN;
      MDU_RUN:  if (count == CW'(WIDTH - 1)) state_next = MDU_FIN;
      MDU_FIN:  state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            op_a   <= mag_a;
            op_b   <= mag_b;
            // Divide-by-zero keeps the all-ones quotient unnegated; remainder then restores reg_a.
            neg_q  <= (sign_a ^ sign_b) & ~(op_div && (bus.reg_b == '0));
            neg_r  <= sign_a;
            is_div <= op_div;
            acc    <= '0;
            count  <= '0;
          end else begin
            if (bus.wr_hi) hi_reg <= bus.wr_data;
            if (bus.wr_lo) lo_reg <= bus.wr_data;
          end
        end
        MDU_RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            acc  <= acc_div;
            op_a <= {op_a[WIDTH-2:0], 1'b0};
          end else begin
            acc  <= acc_mul;
            op_b <= op_b >> 1;
          end
        end
        MDU_FIN: begin
          if (is_div) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
          end
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != MDU_IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

`default_nettype wire
